fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS core, the next generation of the two-source EX forwarding logic. It selects EX operand bypass from up to NUM_SRC later pipeline stages by priority, detects load-use hazards, and tracks one outstanding long-latency operation (mult/div) with a registered scoreboard that stalls decode on RAW, WAW and structural conflicts. It sits beside the ID/EX pipeline register and drives the EX operand muxes and the F/D stall and E flush controls.

## Interface
- ADDR_W, 5, register address width
- NUM_SRC, 2, forwarding source stages; index 0 is nearest to EX (M), index 1 is next (W), and so on
- LAT_W, 3, width of the long-op latency field
- CNT_W, 16, width of the stall statistics counter
- SEL_W, $clog2(NUM_SRC+1), width of the forward select outputs
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_D, rt_D  in  ADDR_W  decode-stage source registers
- wr_addr_D  in  ADDR_W  decode-stage destination register
- reg_write_D  in  1  decode instruction writes wr_addr_D
- long_op_D  in  1  decode instruction is a long-latency op
- rs_E, rt_E  in  ADDR_W  EX-stage source registers
- reg_write_E, mem_to_reg_E  in  1  EX instruction writes a register / is a load
- wr_addr_E  in  ADDR_W  EX destination register
- long_issue_E  in  1  long op issues from EX this cycle
- long_lat_E  in  LAT_W  long op latency in cycles
- long_addr_E  in  ADDR_W  long op destination register
- wr_valid_S  in  NUM_SRC  per-source RegWrite
- wr_addr_S  in  NUM_SRC*ADDR_W  per-source destination, source k at bits [k*ADDR_W +: ADDR_W]
- forward_a, forward_b  out  SEL_W  0 = register file, k+1 = source k
- stall_F, stall_D, flush_E  out  1  hold PC, hold IF/ID, bubble ID/EX
- busy  out  1  scoreboard holds an outstanding long op
- sb_err  out  1  sticky: long issue seen while busy
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Forwarding is combinational. forward_a = k+1 for the lowest k with wr_valid_S[k], wr_addr_S[k] != 0 and wr_addr_S[k] == rs_E. Otherwise forward_a = 0. forward_b is the same function of rt_E.
- Register 0 is never forwarded and never causes a hazard anywhere in this block.
- Load-use hazard: asserted when reg_write_E, mem_to_reg_E and wr_addr_E != 0 are all true, and wr_addr_E equals rs_D or rt_D.
- Scoreboard states are IDLE and BUSY, held in registered dest and cnt fields.
  - IDLE -> BUSY: on long_issue_E. Load dest = long_addr_E and cnt = max(long_lat_E, 1).
  - BUSY, cnt > 1: cnt decrements each cycle.
  - BUSY, cnt == 1: next state is IDLE and cnt = 0.
- busy = (state == BUSY).
- Scoreboard hazard: asserted while BUSY when any of the following holds:
  - dest != 0 and (rs_D == dest or rt_D == dest).
  - reg_write_D and wr_addr_D == dest (WAW).
  - long_op_D (structural).
- stall_F = stall_D = flush_E = load-use hazard OR scoreboard hazard.
- long_issue_E while BUSY is ignored: state, dest and cnt are unchanged, and sb_err sets. sb_err stays set until reset.
- The long unit writes its result to the register file during the last BUSY cycle (cnt == 1). The register file is write-first, so decode reads the new value in that cycle.
- stall_cnt increments on every cycle with stall_D = 1 and saturates at all-ones.

## Timing
- Reset, asynchronous: state = IDLE, dest = 0, cnt = 0, sb_err = 0, stall_cnt = 0.
  - During reset, busy = 0.
  - The combinational outputs follow their inputs with the scoreboard term = 0.
- forward_a/b, stall_F, stall_D and flush_E have zero-cycle combinational latency from their inputs and from registered state.
- Long op sampled on edge 0 with latency L:
  - busy is high for exactly L cycles, from after edge 0 through edge L.
  - A dependent decode instruction stalls for those L cycles and proceeds in the cycle after edge L.
- A load-use stall lasts exactly one cycle once the load leaves EX.
- Simultaneous load-use and scoreboard hazards produce a single OR'd stall. stall_cnt increments once per cycle.
- Issue on the same edge that BUSY retires (cnt == 1) is treated as issue while BUSY: it is ignored and sb_err sets.
- Reset mid-operation clears BUSY immediately. Stalls drop in the same cycle unless load-use applies.

## Test plan
- NUM_SRC=3; wr_valid_S=3'b111, all wr_addr_S=5, rs_E=5 -> forward_a=1. Drop wr_valid_S[0] -> forward_a=2. Set all wr_addr_S=0 with rs_E=0 -> forward_a=0.
- Load in EX writing r8 with rt_D=8 -> stall_F, stall_D and flush_E high for one cycle; stall_cnt goes 0 -> 1.
- long_issue_E with long_lat_E=4, long_addr_E=r3; rs_D=3 held -> busy and stall high for 4 cycles, then low; long_lat_E=0 -> busy for 1 cycle.
- While BUSY on dest r3: reg_write_D with wr_addr_D=3 -> stall (WAW); long_op_D=1 -> stall; rs_D=4 with no write and no long op -> no stall.
- Force long_issue_E while BUSY -> dest and cnt unchanged, sb_err=1 and held; rst_n pulsed low mid-BUSY -> busy=0, sb_err=0, stall_cnt=0 immediately.
- CNT_W=4; hold stall for 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding select, load-use detection and a one-entry long-op
// scoreboard that stalls decode on RAW/WAW/structural conflicts.
//
// state | meaning
// IDLE  | no long-latency op outstanding
// BUSY  | long op in flight; dest_q holds its target, cnt_q the cycles left
module fwd_hazard_unit #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         rs_D,
    input  logic [ADDR_W-1:0]         rt_D,
    input  logic [ADDR_W-1:0]         wr_addr_D,
    input  logic                      reg_write_D,
    input  logic                      long_op_D,
    input  logic [ADDR_W-1:0]         rs_E,
    input  logic [ADDR_W-1:0]         rt_E,
    input  logic                      reg_write_E,
    input  logic                      mem_to_reg_E,
    input  logic [ADDR_W-1:0]         wr_addr_E,
    input  logic                      long_issue_E,
    input  logic [LAT_W-1:0]          long_lat_E,
    input  logic [ADDR_W-1:0]         long_addr_E,
    input  logic [NUM_SRC-1:0]        wr_valid_S,
    input  logic [NUM_SRC*ADDR_W-1:0] wr_addr_S,
    output logic [SEL_W-1:0]          forward_a,
    output logic [SEL_W-1:0]          forward_b,
    output logic                      stall_F,
    output logic                      stall_D,
    output logic                      flush_E,
    output logic                      busy,
    output logic                      sb_err,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [LAT_W-1:0]    cnt_q, cnt_d;
    logic                sb_err_q, sb_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                load_use;
    logic                sb_haz;
    logic                stall;

    // Scan from the farthest source down so the nearest matching stage wins.
    always_comb begin
        forward_a = '0;
        forward_b = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (wr_valid_S[k] && (wr_addr_S[k*ADDR_W +: ADDR_W] != '0)) begin
                if (wr_addr_S[k*ADDR_W +: ADDR_W] == rs_E) forward_a = SEL_W'(k + 1);
                if (wr_addr_S[k*ADDR_W +: ADDR_W] == rt_E) forward_b = SEL_W'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            cnt_q       <= '0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            cnt_q       <= cnt_d;
            sb_err_q    <= sb_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // An issue while BUSY (including the retiring cycle) is dropped, only flagged.
    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        case (state_q)
            IDLE: begin
                if (long_issue_E) begin
                    state_d = BUSY;
                    dest_d  = long_addr_E;
                    cnt_d   = (long_lat_E == '0) ? LAT_W'(1) : long_lat_E;
                end
            end
            BUSY: begin
                if (long_issue_E) sb_err_d = 1'b1;
                if (cnt_q > LAT_W'(1)) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_comb begin
        busy     = (state_q == BUSY);
        load_use = reg_write_E && mem_to_reg_E && (wr_addr_E != '0) &&
                   ((wr_addr_E == rs_D) || (wr_addr_E == rt_D));
        sb_haz   = busy && (((dest_q != '0) && ((rs_D == dest_q) || (rt_D == dest_q))) ||
                            (reg_write_D && (wr_addr_D != '0) && (wr_addr_D == dest_q)) ||
                            long_op_D);
        stall     = load_use || sb_haz;
        stall_F   = stall;
        stall_D   = stall;
        flush_E   = stall;
        sb_err    = sb_err_q;
        stall_cnt = stall_cnt_q;
    end

endmodule
